// File: rtl/pkt_len_tracker.sv
// pkt_len_tracker: passive AXI-Stream tap that checks each packet's beat count
// against the length field in its header and stalls header parsing while payload
// beats are in flight.
// Optional statistics counters are enabled by defining PKT_LEN_TRACKER_STATS_EN.
module pkt_len_tracker #(
    parameter int TDATA_WIDTH    = 64,
    parameter int LEN_LSB        = 0,
    parameter int LEN_WIDTH      = 16,
    parameter int MAX_PKT_LENGTH = 9216,
    localparam int BYTES         = TDATA_WIDTH / 8,
    localparam int MAX_BEATS     = 1 + (MAX_PKT_LENGTH + BYTES - 1) / BYTES,
    localparam int CNT_W         = $clog2(MAX_BEATS + 1)
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   s_tvalid,
    input  logic                   s_tready,
    input  logic [TDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
`ifdef PKT_LEN_TRACKER_STATS_EN
    input  logic                   stats_clr,
    output logic [31:0]            good_pkt_cnt,
    output logic [31:0]            err_pkt_cnt,
`endif
    output logic                   hdr_valid,
    output logic [LEN_WIDTH-1:0]   pkt_length,
    output logic [CNT_W-1:0]       beats_expected,
    output logic [CNT_W-1:0]       beat_cnt,
    output logic                   payload_active,
    output logic                   pkt_done,
    output logic                   err_short,
    output logic                   err_long,
    output logic                   err_oversize
);

    localparam int SHIFT = $clog2(BYTES);
    localparam logic [LEN_WIDTH:0] ROUND = (LEN_WIDTH + 1)'(BYTES - 1);
    localparam logic [31:0] MAX_LEN = 32'(MAX_PKT_LENGTH);

    typedef enum logic [1:0] {IDLE, PAYLOAD, DRAIN} state_t;

    state_t state, state_n;
    logic beat, oversize, unused_tdata;
    logic [LEN_WIDTH-1:0] len, pkt_length_n;
    logic [LEN_WIDTH:0] len_beats;
    logic [CNT_W-1:0] hdr_exp, cnt_inc, cnt_sat, beats_expected_n, beat_cnt_n;
    logic hdr_valid_n, pkt_done_n, err_short_n, err_long_n, err_oversize_n;

    assign beat         = s_tvalid & s_tready;
    assign len          = s_tdata[LEN_LSB +: LEN_WIDTH];
    // Only the length field is consumed; the rest of the beat is folded into a sink.
    assign unused_tdata = ^s_tdata;
    // One extra bit keeps the round-up sum from wrapping for the largest length.
    assign len_beats    = ({1'b0, len} + ROUND) >> SHIFT;
    assign hdr_exp      = CNT_W'(len_beats + (LEN_WIDTH + 1)'(1));
    assign oversize     = 32'(len) > MAX_LEN;
    assign cnt_inc      = beat_cnt + CNT_W'(1);
    assign cnt_sat      = &beat_cnt ? beat_cnt : cnt_inc;

    // Next-state and next-output decode for every accepted beat.
    always_comb begin
        state_n          = state;
        pkt_length_n     = pkt_length;
        beats_expected_n = beats_expected;
        beat_cnt_n       = beat_cnt;
        hdr_valid_n      = 1'b0;
        pkt_done_n       = 1'b0;
        err_short_n      = 1'b0;
        err_long_n       = 1'b0;
        err_oversize_n   = 1'b0;
        case (state)
            IDLE: if (beat) begin
                pkt_length_n     = len;
                beats_expected_n = hdr_exp;
                beat_cnt_n       = CNT_W'(1);
                hdr_valid_n      = 1'b1;
                if (oversize) begin
                    err_oversize_n = 1'b1;
                    pkt_done_n     = s_tlast;
                    state_n        = s_tlast ? IDLE : DRAIN;
                end else if (s_tlast) begin
                    pkt_done_n  = 1'b1;
                    err_short_n = hdr_exp > CNT_W'(1);
                end else begin
                    err_long_n = hdr_exp == CNT_W'(1);
                    state_n    = (hdr_exp == CNT_W'(1)) ? DRAIN : PAYLOAD;
                end
            end
            PAYLOAD: if (beat) begin
                beat_cnt_n = cnt_inc;
                if (s_tlast) begin
                    pkt_done_n  = 1'b1;
                    err_short_n = cnt_inc < beats_expected;
                    state_n     = IDLE;
                end else if (cnt_inc == beats_expected) begin
                    err_long_n = 1'b1;
                    state_n    = DRAIN;
                end
            end
            DRAIN: if (beat) begin
                beat_cnt_n = cnt_sat;
                pkt_done_n = s_tlast;
                state_n    = s_tlast ? IDLE : DRAIN;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register and registered outputs; reset abandons any packet in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= IDLE;
            pkt_length     <= '0;
            beats_expected <= '0;
            beat_cnt       <= '0;
            hdr_valid      <= 1'b0;
            payload_active <= 1'b0;
            pkt_done       <= 1'b0;
            err_short      <= 1'b0;
            err_long       <= 1'b0;
            err_oversize   <= 1'b0;
        end else begin
            state          <= state_n;
            pkt_length     <= pkt_length_n;
            beats_expected <= beats_expected_n;
            beat_cnt       <= beat_cnt_n;
            hdr_valid      <= hdr_valid_n;
            payload_active <= state_n != IDLE;
            pkt_done       <= pkt_done_n;
            err_short      <= err_short_n;
            err_long       <= err_long_n;
            err_oversize   <= err_oversize_n;
        end
    end

`ifdef PKT_LEN_TRACKER_STATS_EN
    logic err_seen, pkt_bad;

    assign pkt_bad = err_seen | err_short_n | err_long_n | err_oversize_n;

    // Per-packet tally: errors earlier in the packet are remembered until it closes.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_seen     <= 1'b0;
            good_pkt_cnt <= '0;
            err_pkt_cnt  <= '0;
        end else begin
            err_seen <= pkt_done_n ? 1'b0 : (err_seen | err_long_n | err_oversize_n);
            if (stats_clr) begin
                good_pkt_cnt <= '0;
                err_pkt_cnt  <= '0;
            end else if (pkt_done_n) begin
                if (pkt_bad)
                    err_pkt_cnt <= &err_pkt_cnt ? err_pkt_cnt : err_pkt_cnt + 32'd1;
                else
                    good_pkt_cnt <= &good_pkt_cnt ? good_pkt_cnt : good_pkt_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pkt_len_tracker.sv
// tb_pkt_len_tracker: vector table, corner sequences and random traffic against a packet-level model.
module tb_pkt_len_tracker;

    localparam int W     = 64;
    localparam int MAXL  = 9216;
    localparam int BYTES = W / 8;
    localparam int CNT_W = $clog2(1 + (MAXL + BYTES - 1) / BYTES + 1);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic aclk = 1'b0, aresetn = 1'b1;
    logic s_tvalid = 1'b0, s_tready = 1'b0, s_tlast = 1'b0;
    logic [W-1:0] s_tdata = '0;
    logic hdr_valid, payload_active, pkt_done, err_short, err_long, err_oversize;
    logic [15:0] pkt_length;
    logic [CNT_W-1:0] beats_expected, beat_cnt;

    pkt_len_tracker #(.TDATA_WIDTH(W), .LEN_LSB(0), .LEN_WIDTH(16), .MAX_PKT_LENGTH(MAXL)) dut (
        .aclk(aclk), .aresetn(aresetn), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tdata(s_tdata), .s_tlast(s_tlast), .hdr_valid(hdr_valid), .pkt_length(pkt_length),
        .beats_expected(beats_expected), .beat_cnt(beat_cnt), .payload_active(payload_active),
        .pkt_done(pkt_done), .err_short(err_short), .err_long(err_long), .err_oversize(err_oversize)
    );

    always #5 aclk = ~aclk;

    int tests = 0, fails = 0;

    // Packet-level reference: beats seen in the current packet, its expected total,
    // and whether the rest of it is being discarded (oversize or already overrun).
    bit m_in, m_disc;
    int m_n, m_e, m_len;
    bit e_hdr, e_done, e_es, e_el, e_eo;

    typedef struct {
        logic v, r, l;
        logic [15:0] len;
        logic hdr, done, es, el, eo, pa;
        int bc, be, pl;
    } vec_t;
    vec_t tbl[21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_in = 0; m_disc = 0; m_n = 0; m_e = 0; m_len = 0;
        {e_hdr, e_done, e_es, e_el, e_eo} = '0;
    endfunction

    function automatic void model_beat(input logic v, input logic r, input logic [W-1:0] d, input logic l);
        {e_hdr, e_done, e_es, e_el, e_eo} = '0;
        if (!(v && r)) return;
        if (!m_in) begin
            m_len  = int'(d[15:0]);
            m_e    = 1 + (m_len + BYTES - 1) / BYTES;
            m_n    = 1;
            e_hdr  = 1;
            m_disc = m_len > MAXL;
            e_eo   = m_disc;
        end else m_n++;
        if (!m_disc && l && m_n < m_e) e_es = 1;
        if (!m_disc && !l && m_n == m_e) begin
            e_el   = 1;
            m_disc = 1;
        end
        e_done = l;
        m_in   = !l;
    endfunction

    task automatic check_model();
        chk("hdr_valid", hdr_valid, e_hdr);
        chk("pkt_done", pkt_done, e_done);
        chk("err_short", err_short, e_es);
        chk("err_long", err_long, e_el);
        chk("err_oversize", err_oversize, e_eo);
        chk("payload_active", payload_active, m_in);
        chk("pkt_length", pkt_length, m_len);
        chk("beats_expected", beats_expected, m_e % (CMAX + 1));
        chk("beat_cnt", beat_cnt, (m_n > CMAX) ? CMAX : m_n);
    endtask

    task automatic cyc(input logic v, input logic r, input logic [W-1:0] d, input logic l);
        s_tvalid = v; s_tready = r; s_tdata = d; s_tlast = l;
        @(posedge aclk);
        model_beat(v, r, d, l);
        @(negedge aclk);
        check_model();
    endtask

    task automatic do_reset();
        #2 aresetn = 1'b0;
        model_reset();
        #1 check_model();
        s_tvalid = 1'b1; s_tready = 1'b1; s_tlast = 1'b0; s_tdata = {$urandom, $urandom};
        repeat (2) @(negedge aclk);
        check_model();
        aresetn = 1'b1;
    endtask

    function automatic logic [W-1:0] hdr(input logic [15:0] len);
        return {48'hA5A5_5A5A_C3C3, len};
    endfunction

    initial begin
        tbl = '{
            '{1,1,0,16'd20,    1,0,0,0,0,1, 1,4,20},
            '{1,1,0,16'hFFFF,  0,0,0,0,0,1, 2,4,20},
            '{1,1,0,16'hFFFF,  0,0,0,0,0,1, 3,4,20},
            '{1,1,1,16'hFFFF,  0,1,0,0,0,0, 4,4,20},
            '{1,1,1,16'd0,     1,1,0,0,0,0, 1,1,0},
            '{1,1,0,16'd24,    1,0,0,0,0,1, 1,4,24},
            '{1,1,0,16'hFFFF,  0,0,0,0,0,1, 2,4,24},
            '{1,1,1,16'hFFFF,  0,1,1,0,0,0, 3,4,24},
            '{1,1,0,16'd8,     1,0,0,0,0,1, 1,2,8},
            '{1,1,0,16'hFFFF,  0,0,0,1,0,1, 2,2,8},
            '{1,1,0,16'hFFFF,  0,0,0,0,0,1, 3,2,8},
            '{1,1,0,16'hFFFF,  0,0,0,0,0,1, 4,2,8},
            '{1,1,1,16'hFFFF,  0,1,0,0,0,0, 5,2,8},
            '{0,0,0,16'd0,     0,0,0,0,0,0, 5,2,8},
            '{1,1,0,16'd9217,  1,0,0,0,1,1, 1,1154,9217},
            '{1,1,0,16'hFFFF,  0,0,0,0,0,1, 2,1154,9217},
            '{1,1,1,16'hFFFF,  0,1,0,0,0,0, 3,1154,9217},
            '{1,0,1,16'd30,    0,0,0,0,0,0, 3,1154,9217},
            '{1,1,1,16'd9216,  1,1,1,0,0,0, 1,1153,9216},
            '{1,1,0,16'd0,     1,0,0,1,0,1, 1,1,0},
            '{1,1,1,16'hFFFF,  0,1,0,0,0,0, 2,1,0}
        };
        model_reset();
        do_reset();

        for (int i = 0; i < 21; i++) begin
            cyc(tbl[i].v, tbl[i].r, hdr(tbl[i].len), tbl[i].l);
            chk($sformatf("tbl%0d_hdr", i), hdr_valid, tbl[i].hdr);
            chk($sformatf("tbl%0d_done", i), pkt_done, tbl[i].done);
            chk($sformatf("tbl%0d_short", i), err_short, tbl[i].es);
            chk($sformatf("tbl%0d_long", i), err_long, tbl[i].el);
            chk($sformatf("tbl%0d_over", i), err_oversize, tbl[i].eo);
            chk($sformatf("tbl%0d_active", i), payload_active, tbl[i].pa);
            chk($sformatf("tbl%0d_cnt", i), beat_cnt, tbl[i].bc);
            chk($sformatf("tbl%0d_exp", i), beats_expected, tbl[i].be);
            chk($sformatf("tbl%0d_len", i), pkt_length, tbl[i].pl);
        end

        // Stalled beats mid-packet, then reset during PAYLOAD.
        cyc(1, 1, hdr(16'd40), 0);
        chk("s6_exp", beats_expected, 6);
        cyc(1, 1, hdr(16'hFFFF), 0);
        repeat (3) cyc(1, 0, hdr(16'hFFFF), 1);
        chk("s6_stall_cnt", beat_cnt, 2);
        chk("s6_stall_active", payload_active, 1);
        cyc(1, 1, hdr(16'hFFFF), 0);
        chk("s6_cnt3", beat_cnt, 3);
        do_reset();
        chk("s6_rst_active", payload_active, 0);
        chk("s6_rst_len", pkt_length, 0);
        cyc(1, 1, hdr(16'd16), 1);
        chk("s6_post_hdr", hdr_valid, 1);
        chk("s6_post_len", pkt_length, 16);
        chk("s6_post_short", err_short, 1);

        for (int i = 0; i < 4000; i++) begin
            logic v, r, l;
            logic [W-1:0] d;
            int k, len;
            v = $urandom_range(0, 3) != 0;
            r = $urandom_range(0, 3) != 0;
            l = $urandom_range(0, 5) == 0;
            k = $urandom_range(0, 9);
            len = (k < 7) ? $urandom_range(0, 64) : (k < 9) ? $urandom_range(9200, 9232) : $urandom_range(0, 65535);
            d = {$urandom, $urandom};
            d[15:0] = len[15:0];
            if ($urandom_range(0, 999) == 0) do_reset();
            cyc(v, r, d, l);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
